// File: rtl/iobuf_half_duplex_ctrl_if.sv
// Fabric-side request/response and pad-side I/T/O signals of the half-duplex pad sequencer.
// Handshake: WR_REQ/RD_REQ are accepted on a rising clock edge only while BUSY is low; a request seen while BUSY is high is dropped, never held.
interface iobuf_half_duplex_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             WR_REQ;
    logic [WIDTH-1:0] WR_DATA;
    logic             RD_REQ;
    logic             BUSY;
    logic [WIDTH-1:0] RD_DATA;
    logic             RD_VALID;
    logic [WIDTH-1:0] PAD_I;
    logic             PAD_T;
    logic [WIDTH-1:0] PAD_O;

    modport master (
        output WR_REQ, WR_DATA, RD_REQ, PAD_O,
        input  BUSY, RD_DATA, RD_VALID, PAD_I, PAD_T
    );

    modport slave (
        input  WR_REQ, WR_DATA, RD_REQ, PAD_O,
        output BUSY, RD_DATA, RD_VALID, PAD_I, PAD_T
    );
endinterface

// File: rtl/iobuf_half_duplex_ctrl.sv
// Half-duplex pad sequencer: every bus direction change passes through a released turnaround window.
// Optional macro IOBUF_HALF_DUPLEX_GTS_EN ORs glbl.GTS into PAD_T combinationally.
module iobuf_half_duplex_ctrl #(
    parameter int WIDTH      = 8,
    parameter int TURN_CYC   = 2,
    parameter int SAMPLE_DLY = 1
) (
    input  logic                     C,
    input  logic                     R,
    iobuf_half_duplex_ctrl_if.slave  bus,
    output logic [2:0]               dbg_state
);
    typedef enum logic [2:0] {
        IDLE_Z = 3'd0,
        TURN_D = 3'd1,
        IDLE_D = 3'd2,
        TURN_Z = 3'd3,
        SAMPLE = 3'd4
    } state_t;

    localparam logic [3:0] TURN_LAST   = 4'(TURN_CYC - 1);
    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLE_DLY - 1);

    state_t           state_q, state_n;
    logic [3:0]       cnt_q, cnt_n;
    logic [WIDTH-1:0] wdata_q, wdata_n;
    logic [WIDTH-1:0] pad_i_q, pad_i_n;
    logic             pad_t_q, pad_t_n;
    logic             busy_q, busy_n;
    logic [WIDTH-1:0] rd_data_q, rd_data_n;
    logic             rd_valid_q, rd_valid_n;

    always_ff @(posedge C) begin
        if (R) begin
            state_q    <= IDLE_Z;
            cnt_q      <= '0;
            wdata_q    <= '0;
            pad_i_q    <= '0;
            pad_t_q    <= 1'b1;
            busy_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            wdata_q    <= wdata_n;
            pad_i_q    <= pad_i_n;
            pad_t_q    <= pad_t_n;
            busy_q     <= busy_n;
            rd_data_q  <= rd_data_n;
            rd_valid_q <= rd_valid_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        wdata_n    = wdata_q;
        pad_i_n    = pad_i_q;
        rd_data_n  = rd_data_q;
        rd_valid_n = 1'b0;
        case (state_q)
            IDLE_Z: begin
                if (bus.WR_REQ) begin
                    wdata_n = bus.WR_DATA;
                    cnt_n   = '0;
                    state_n = TURN_D;
                end else if (bus.RD_REQ) begin
                    cnt_n   = '0;
                    state_n = SAMPLE;
                end
            end
            TURN_D: begin
                if (cnt_q == TURN_LAST) begin
                    cnt_n   = '0;
                    pad_i_n = wdata_q;
                    state_n = IDLE_D;
                end else begin
                    cnt_n = cnt_q + 4'd1;
                end
            end
            IDLE_D: begin
                // Already driving: back-to-back writes update the pad with no turnaround.
                if (bus.WR_REQ) begin
                    wdata_n = bus.WR_DATA;
                    pad_i_n = bus.WR_DATA;
                end else if (bus.RD_REQ) begin
                    cnt_n   = '0;
                    state_n = TURN_Z;
                end
            end
            TURN_Z: begin
                if (cnt_q == TURN_LAST) begin
                    cnt_n   = '0;
                    state_n = SAMPLE;
                end else begin
                    cnt_n = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    cnt_n      = '0;
                    rd_data_n  = bus.PAD_O;
                    rd_valid_n = 1'b1;
                    state_n    = IDLE_Z;
                end else begin
                    cnt_n = cnt_q + 4'd1;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE_Z;
            end
        endcase
        // BUSY and PAD_T are registered copies of what the next state implies.
        busy_n  = (state_n == TURN_D) || (state_n == TURN_Z) || (state_n == SAMPLE);
        pad_t_n = (state_n != IDLE_D);
    end

    assign bus.BUSY     = busy_q;
    assign bus.RD_DATA  = rd_data_q;
    assign bus.RD_VALID = rd_valid_q;
    assign bus.PAD_I    = pad_i_q;
    assign dbg_state    = state_q;

`ifdef IOBUF_HALF_DUPLEX_GTS_EN
    assign bus.PAD_T = pad_t_q | glbl.GTS;
`else
    assign bus.PAD_T = pad_t_q;
`endif

endmodule
